r2r_dac_wavegen: RTL and testbench



---
 rtl/r2r_dac_wavegen.sv | 124 ++++++++++++
 tb/tb_r2r_dac_wavegen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/r2r_dac_wavegen.sv
// R2R ladder driver: external sample pass-through or divided-rate hold/saw/triangle/square engine.
// Optional macro WAVE_SYNC_EN adds a wave_sync pulse marking the start of each waveform period.
module r2r_dac_wavegen #(
  parameter int DAC_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             ext_data,
  input  logic [1:0]       mode,
  input  logic [7:0]       data,
  input  logic             load_divider,
  output logic             cnt_zero,
`ifdef WAVE_SYNC_EN
  output logic             wave_sync,
`endif
  output logic [DAC_W-1:0] r2r_out
);

  typedef enum logic [1:0] {MODE_HOLD, MODE_SAW, MODE_TRI, MODE_SQR} mode_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  localparam logic [DAC_W-1:0] OUT_MAX = '1;

  logic [DIV_W-1:0] div_reg, div_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DAC_W-1:0] out_nxt, ext_val;
  dir_t             dir, dir_eff, dir_nxt;
  mode_t            mode_q, mode_in;
  logic             tick, step, cnt_zero_nxt;

  // External bytes land in the top 8 bits of the ladder word.
  assign ext_val = DAC_W'(data) << (DAC_W - 8);
  assign mode_in = mode_t'(mode);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tick         = (cnt == '0);
    step         = tick & ~load_divider;
    cnt_zero_nxt = step;
    div_nxt      = div_reg;
    cnt_nxt      = cnt - 1'b1;
    // A mode change restarts the direction so a fresh triangle always begins rising.
    dir_eff      = (mode_in != mode_q) ? DIR_UP : dir;
    dir_nxt      = dir_eff;
    out_nxt      = r2r_out;

    if (load_divider) begin
      div_nxt = data[DIV_W-1:0];
      cnt_nxt = data[DIV_W-1:0];
    end else if (tick) begin
      cnt_nxt = div_reg;
    end

    if (ext_data) begin
      out_nxt = ext_val;
    end else if (step) begin
      unique case (mode_in)
        MODE_HOLD: out_nxt = r2r_out;
        MODE_SAW:  out_nxt = r2r_out + 1'b1;
        MODE_TRI: begin
          if (dir_eff == DIR_UP) begin
            if (r2r_out == OUT_MAX) begin
              dir_nxt = DIR_DOWN;
              out_nxt = OUT_MAX - 1'b1;
            end else begin
              out_nxt = r2r_out + 1'b1;
            end
          end else begin
            if (r2r_out == '0) begin
              dir_nxt = DIR_UP;
              out_nxt = DAC_W'(1);
            end else begin
              out_nxt = r2r_out - 1'b1;
            end
          end
        end
        MODE_SQR:  out_nxt = (r2r_out == '0) ? OUT_MAX : '0;
        default:   out_nxt = r2r_out;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      div_reg  <= '0;
      cnt      <= '0;
      cnt_zero <= 1'b0;
      dir      <= DIR_UP;
      mode_q   <= MODE_HOLD;
      r2r_out  <= '0;
    end else begin
      div_reg  <= div_nxt;
      cnt      <= cnt_nxt;
      cnt_zero <= cnt_zero_nxt;
      dir      <= dir_nxt;
      mode_q   <= mode_in;
      r2r_out  <= out_nxt;
    end
  end

`ifdef WAVE_SYNC_EN
  logic sync_nxt;

  always_comb begin
    sync_nxt = 1'b0;
    if (step && !ext_data) begin
      unique case (mode_in)
        MODE_SAW: sync_nxt = (r2r_out == OUT_MAX);
        MODE_TRI: sync_nxt = (dir_eff == DIR_DOWN) && (r2r_out == DAC_W'(1));
        MODE_SQR: sync_nxt = (r2r_out == '0);
        default:  sync_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) wave_sync <= 1'b0;
    else        wave_sync <= sync_nxt;
  end
`endif

endmodule

// File: tb/tb_r2r_dac_wavegen.sv
// Self-checking bench for r2r_dac_wavegen: directed phases plus random stimulus against an integer model.
// Two instances (DAC_W=8 and DAC_W=10) share all inputs.
module tb_r2r_dac_wavegen;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        ext_data;
  logic [1:0]  mode;
  logic [7:0]  data;
  logic        load_divider;
  logic        cnt_zero_a, cnt_zero_b;
  logic [7:0]  out_a;
  logic [9:0]  out_b;
`ifdef WAVE_SYNC_EN
  logic        sync_a, sync_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: index 0 is the 8-bit instance, index 1 the 10-bit one.
  int m_out[2];
  int m_dir[2];
  int m_ws[2];
  int m_div, m_cnt, m_cz, m_mode_q;

  r2r_dac_wavegen #(.DAC_W(8), .DIV_W(8)) dut_a (
    .clk(clk), .n_rst(n_rst), .ext_data(ext_data), .mode(mode), .data(data),
    .load_divider(load_divider), .cnt_zero(cnt_zero_a),
`ifdef WAVE_SYNC_EN
    .wave_sync(sync_a),
`endif
    .r2r_out(out_a)
  );

  r2r_dac_wavegen #(.DAC_W(10), .DIV_W(8)) dut_b (
    .clk(clk), .n_rst(n_rst), .ext_data(ext_data), .mode(mode), .data(data),
    .load_divider(load_divider), .cnt_zero(cnt_zero_b),
`ifdef WAVE_SYNC_EN
    .wave_sync(sync_b),
`endif
    .r2r_out(out_b)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int w, maxv, tick, step, chg;
    if (!n_rst) begin
      m_div = 0; m_cnt = 0; m_cz = 0; m_mode_q = 0;
      for (int k = 0; k < 2; k++) begin
        m_out[k] = 0; m_dir[k] = 1; m_ws[k] = 0;
      end
      return;
    end
    tick = (m_cnt == 0);
    step = tick && !load_divider;
    if (load_divider) begin
      m_div = int'(data);
      m_cnt = m_div;
    end else if (tick) m_cnt = m_div;
    else m_cnt = m_cnt - 1;
    m_cz = step;
    chg = (int'(mode) != m_mode_q);
    m_mode_q = int'(mode);
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 8 : 10;
      maxv = (1 << w) - 1;
      m_ws[k] = 0;
      if (chg) m_dir[k] = 1;
      if (ext_data) m_out[k] = int'(data) * (1 << (w - 8));
      else if (step) begin
        case (mode)
          2'd1: begin
            m_out[k] = (m_out[k] + 1) % (maxv + 1);
            if (m_out[k] == 0) m_ws[k] = 1;
          end
          2'd2: begin
            if (m_dir[k] > 0 && m_out[k] == maxv) begin
              m_dir[k] = -1; m_out[k] = maxv - 1;
            end else if (m_dir[k] < 0 && m_out[k] == 0) begin
              m_dir[k] = 1; m_out[k] = 1;
            end else begin
              m_out[k] = m_out[k] + m_dir[k];
              if (m_out[k] == 0) m_ws[k] = 1;
            end
          end
          2'd3: begin
            if (m_out[k] == 0) begin
              m_out[k] = maxv; m_ws[k] = 1;
            end else m_out[k] = 0;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".out8"},  32'(out_a), 32'(m_out[0]));
    check({tag, ".out10"}, 32'(out_b), 32'(m_out[1]));
    check({tag, ".cz8"},   32'(cnt_zero_a), 32'(m_cz));
    check({tag, ".cz10"},  32'(cnt_zero_b), 32'(m_cz));
`ifdef WAVE_SYNC_EN
    check({tag, ".ws8"},   32'(sync_a), 32'(m_ws[0]));
    check({tag, ".ws10"},  32'(sync_b), 32'(m_ws[1]));
`endif
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic load_div(input logic [7:0] v);
    load_divider = 1'b1; data = v;
    cycle("load");
    load_divider = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; ext_data = 1'b0; mode = 2'b01; data = 8'h00; load_divider = 1'b0;
    run("reset", 3);
    check("reset.out_zero", 32'(out_a), 32'd0);
    check("reset.cz_zero", 32'(cnt_zero_a), 32'd0);

    // Sawtooth, divide by 1, long enough to wrap.
    n_rst = 1'b1;
    cycle("saw_first");
    check("saw_first.out", 32'(out_a), 32'd1);
    check("saw_first.cz", 32'(cnt_zero_a), 32'd1);
    run("saw", 300);

    // Divide by 4: load edge does not step.
    load_div(8'd3);
    run("saw_div4", 20);

    // Triangle from 253 at full rate, through both turn-arounds.
    load_div(8'd0);
    ext_data = 1'b1; data = 8'd253;
    cycle("ext253");
    check("ext253.out", 32'(out_a), 32'd253);
    ext_data = 1'b0; mode = 2'b10;
    run("tri", 520);

    // Square at half rate, then external sample 0xA5.
    load_div(8'd1);
    mode = 2'b11;
    run("sqr", 12);
    ext_data = 1'b1; data = 8'hA5;
    cycle("extA5");
    check("extA5.out8", 32'(out_a), 32'h0A5);
    check("extA5.out10", 32'(out_b), 32'h294);
    run("extA5_hold", 3);

    // Reset while the triangle is falling, then restart.
    load_div(8'd0);
    data = 8'd200;
    cycle("ext200");
    ext_data = 1'b0; mode = 2'b10;
    run("tri_hi", 70);
    n_rst = 1'b0;
    run("mid_reset", 2);
    check("mid_reset.out", 32'(out_a), 32'd0);
    n_rst = 1'b1;
    run("tri_restart", 5);
    check("tri_restart.out", 32'(out_a), 32'd5);

    // Random stimulus.
    for (int i = 0; i < 4000; i++) begin
      n_rst        = ($urandom_range(0, 199) != 0);
      load_divider = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) ext_data = ~ext_data;
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      data = 8'($urandom_range(0, 255));
      if (load_divider) data = 8'($urandom_range(0, 5));
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
